// File: rtl/serial_deserializer_if.sv
// Output slot of the serial deserializer: one word with a valid/ready handshake.
// The master drives the word and valid; the slave returns ready.
interface serial_deserializer_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             data_ready;

   modport master (
      output data_out,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_out,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB- or LSB-first and
// presents each word in a one-entry valid/ready slot with a sticky overrun flag.
module serial_deserializer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_valid,
   input  logic             serial_in,
   input  logic             msb_first,
   input  logic             frame_clr,
   output logic             busy,
   output logic [CNT_W-1:0] bit_count,
   output logic             overrun,
   input  logic             overrun_clr,
   serial_deserializer_if.master out_if
);

   typedef enum logic {IDLE, RECV} state_e;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0] bit_cnt_q;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] data_out_q;
   logic             data_valid_q;
   logic             overrun_q;

   logic take_bit, word_done, drain, load, drop;

   // The first bit of a word uses the live msb_first; later bits use the latch.
   always_comb begin
      dir_d     = (state_q == IDLE) ? msb_first : dir_q;
      sreg_d    = dir_d ? {sreg_q[WIDTH-2:0], serial_in}
                        : {serial_in, sreg_q[WIDTH-1:1]};
      take_bit  = bit_valid & ~frame_clr;
      word_done = take_bit & (bit_cnt_q == LAST_BIT);
      drain     = data_valid_q & out_if.data_ready;
      load      = word_done & (~data_valid_q | out_if.data_ready);
      drop      = word_done & data_valid_q & ~out_if.data_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sreg_q       <= '0;
         bit_cnt_q    <= '0;
         dir_q        <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         if (frame_clr) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
         end else if (bit_valid) begin
            sreg_q <= sreg_d;
            dir_q  <= dir_d;
            if (bit_cnt_q == LAST_BIT) begin
               state_q   <= IDLE;
               bit_cnt_q <= '0;
            end else begin
               state_q   <= RECV;
               bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
         end

         if (load) begin
            data_out_q   <= sreg_d;
            data_valid_q <= 1'b1;
         end else if (drain) begin
            data_valid_q <= 1'b0;
         end

         // A drop in the same cycle as overrun_clr leaves the flag set.
         if (drop) begin
            overrun_q <= 1'b1;
         end else if (overrun_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign busy              = (bit_cnt_q != '0);
   assign bit_count         = bit_cnt_q;
   assign overrun           = overrun_q;
   assign out_if.data_out   = data_out_q;
   assign out_if.data_valid = data_valid_q;

endmodule
